prm_edge_chk_engine: RTL and testbench

- Sequential, table-programmable successor to the fixed per-edge obstacle truth-table checkers.
- Holds a sum-of-products table: each term is a care mask plus a value over VAR_W joint/voxel bits.
- Accepts edge queries on a valid/ready stream, scans the table PAR terms per cycle, and returns edge_mask plus the index of the first matching term.
- Sits between the PRM edge generator and the roadmap pruning stage; one instance serves all edges, and the table is reloaded per obstacle set.

---
 rtl/prm_edge_chk_engine.sv | 142 ++++++++++++++
 tb/tb_prm_edge_chk_engine.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/prm_edge_chk_engine.sv
// rtl/prm_edge_chk_engine.sv - table-programmable sum-of-products edge obstacle checker
module prm_edge_chk_engine #(
    parameter int VAR_W = 15,
    parameter int DEPTH = 512,
    parameter int PAR   = 4,
    parameter int IDX_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [VAR_W-1:0] cfg_care,
    input  logic [VAR_W-1:0] cfg_val,
    input  logic             cfg_cnt_we,
    input  logic [IDX_W:0]   cfg_cnt,
    output logic             cfg_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VAR_W-1:0] in_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             edge_mask,
    output logic [IDX_W-1:0] hit_idx,
    output logic             busy
);
    localparam logic [IDX_W:0] L_PAR   = (IDX_W+1)'(PAR);
    localparam logic [IDX_W:0] L_DEPTH = (IDX_W+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Term storage is deliberately unreset so a new obstacle set survives rst_n.
    logic [VAR_W-1:0] r_care [DEPTH];
    logic [VAR_W-1:0] r_val  [DEPTH];

    logic [VAR_W-1:0] r_q;
    logic [IDX_W:0]   r_ptr;
    logic [IDX_W:0]   r_term_cnt;
    logic             r_edge;
    logic [IDX_W-1:0] r_hit;
    logic             r_err;

    logic                      w_in_idle;
    logic [PAR-1:0][IDX_W:0]   w_lane_idx;
    logic [PAR-1:0]            w_lane_hit;
    logic                      w_any_hit;
    logic [IDX_W-1:0]          w_hit_idx;
    logic                      w_scan_end;
    logic [IDX_W:0]            w_cnt_sat;

    assign w_in_idle  = (r_state == S_IDLE);
    assign w_cnt_sat  = (cfg_cnt > L_DEPTH) ? L_DEPTH : cfg_cnt;
    assign w_scan_end = ((r_ptr + L_PAR) >= r_term_cnt);

    for (genvar g = 0; g < PAR; g++) begin : g_lane
        assign w_lane_idx[g] = r_ptr + (IDX_W+1)'(g);
        assign w_lane_hit[g] = (w_lane_idx[g] < r_term_cnt) &&
            (((r_q ^ r_val[w_lane_idx[g][IDX_W-1:0]]) & r_care[w_lane_idx[g][IDX_W-1:0]]) == '0);
    end

    assign w_any_hit = |w_lane_hit;

    // Walk lanes from high to low so the lowest matching index wins.
    always_comb begin
        w_hit_idx = '0;
        for (int j = PAR - 1; j >= 0; j--) begin
            if (w_lane_hit[j]) begin
                w_hit_idx = w_lane_idx[j][IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && cfg_we && w_in_idle) begin
            r_care[cfg_addr] <= cfg_care;
            r_val[cfg_addr]  <= cfg_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_SCAN;
            S_SCAN:  if (w_any_hit || w_scan_end) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q        <= '0;
            r_ptr      <= '0;
            r_term_cnt <= '0;
            r_edge     <= 1'b0;
            r_hit      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= (cfg_we || cfg_cnt_we) && !w_in_idle;
            if (cfg_cnt_we && w_in_idle) begin
                r_term_cnt <= w_cnt_sat;
            end
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_q   <= in_q;
                        r_ptr <= '0;
                    end
                end
                S_SCAN: begin
                    if (w_any_hit) begin
                        r_edge <= 1'b1;
                        r_hit  <= w_hit_idx;
                    end else if (w_scan_end) begin
                        r_edge <= 1'b0;
                        r_hit  <= '0;
                    end else begin
                        r_ptr <= r_ptr + L_PAR;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = w_in_idle;
    assign out_valid = (r_state == S_DONE);
    assign busy      = !w_in_idle;
    assign edge_mask = r_edge;
    assign hit_idx   = r_hit;
    assign cfg_err   = r_err;
endmodule

// File: tb/tb_prm_edge_chk_engine.sv
// tb/tb_prm_edge_chk_engine.sv - scoreboard bench for prm_edge_chk_engine
module tb_prm_edge_chk_engine;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [8:0]  cfg_addr = '0;
    logic [14:0] cfg_care = '0;
    logic [14:0] cfg_val = '0;
    logic        cfg_cnt_we = 1'b0;
    logic [9:0]  cfg_cnt = '0;
    logic        cfg_err;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [14:0] in_q = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        edge_mask;
    logic [8:0]  hit_idx;
    logic        busy;

    prm_edge_chk_engine dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_care(cfg_care), .cfg_val(cfg_val),
        .cfg_cnt_we(cfg_cnt_we), .cfg_cnt(cfg_cnt), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_q(in_q),
        .out_valid(out_valid), .out_ready(out_ready),
        .edge_mask(edge_mask), .hit_idx(hit_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int e;
        int h;
        int lat;
        int acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   seen = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: samples at negedge; inputs change only at posedge+1.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            seen = 0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                cur = exp_q[0];
                if (!seen) begin
                    chk("latency", cyc - cur.acc, cur.lat);
                    seen = 1;
                end
                chk("edge_mask", int'(edge_mask), cur.e);
                chk("hit_idx", int'(hit_idx), cur.h);
                chk("in_ready_in_done", int'(in_ready), 0);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    seen = 0;
                end
            end
        end
    end

    task automatic cfg_term(input int addr, input logic [14:0] care, input logic [14:0] val);
        cfg_we = 1'b1; cfg_addr = 9'(addr); cfg_care = care; cfg_val = val;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic set_cnt(input int n);
        cfg_cnt_we = 1'b1; cfg_cnt = 10'(n);
        @(posedge clk); #1;
        cfg_cnt_we = 1'b0;
    endtask

    task automatic query(input logic [14:0] q, input bit push, input int e, input int h, input int lat);
        int t = 0;
        while (!in_ready && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        in_valid = 1'b1; in_q = q;
        if (push) exp_q.push_back('{e, h, lat, cyc + 1});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_edge_mask", int'(edge_mask), 0);
        chk("rst_hit_idx", int'(hit_idx), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 512; i++) cfg_term(i, 15'h7FFF, 15'h7FFF);

        cfg_term(0, 15'h7FFF, 15'h1234);
        set_cnt(1);
        query(15'h1234, 1, 1, 0, 2);
        drain();
        query(15'h1235, 1, 0, 0, 2);
        drain();

        cfg_term(9, 15'h0003, 15'h0002);
        set_cnt(10);
        query(15'h0006, 1, 1, 9, 4);
        drain();

        cfg_term(5, 15'h000F, 15'h0006);
        cfg_term(6, 15'h0006, 15'h0006);
        query(15'h0006, 1, 1, 5, 3);
        drain();

        cfg_term(12, 15'h4000, 15'h4000);
        set_cnt(12);
        query(15'h4000, 1, 0, 0, 4);
        drain();
        set_cnt(13);
        query(15'h4000, 1, 1, 12, 5);
        drain();

        set_cnt(10);
        out_ready = 1'b0;
        query(15'h0006, 1, 1, 5, 3);
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("hold_reached_done", int'(out_valid), 1);
        repeat (5) @(posedge clk);
        #1;
        cfg_we = 1'b1; cfg_addr = 9'd5; cfg_care = 15'h7FFF; cfg_val = 15'h0000;
        cfg_cnt_we = 1'b1; cfg_cnt = 10'd0;
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_cnt_we = 1'b0;
        chk("cfg_err_pulse", int'(cfg_err), 1);
        @(posedge clk); #1;
        chk("cfg_err_clear", int'(cfg_err), 0);
        out_ready = 1'b1;
        drain();
        query(15'h0006, 1, 1, 5, 3);
        drain();

        set_cnt(0);
        query(15'h0006, 1, 0, 0, 2);
        drain();

        cfg_term(511, 15'h7FFF, 15'h0ABC);
        set_cnt(600);
        query(15'h0ABC, 1, 1, 511, 129);
        drain();
        set_cnt(511);
        query(15'h0ABC, 1, 0, 0, 129);
        drain();

        set_cnt(10);
        query(15'h0006, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midscan_rst_out_valid", int'(out_valid), 0);
        chk("midscan_rst_in_ready", int'(in_ready), 1);
        chk("midscan_rst_busy", int'(busy), 0);
        set_cnt(10);
        query(15'h0006, 1, 1, 5, 3);
        drain();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
